// File: rtl/exu_mc_pkg.sv
// Shared RV32I encodings and FSM state encoding for the exu_mc execute unit.
// The MUL states exist only when EXU_MC_MUL_EN is defined.
package exu_mc_pkg;

    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_LUI = 7'b0110111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_BEQ     = 3'b000;
    localparam logic [2:0] F3_BNE     = 3'b001;
    localparam logic [2:0] F3_MUL     = 3'b000;

    localparam logic [6:0] F7_ADD    = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

`ifdef EXU_MC_MUL_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exu_state_t;
`endif

    // Iteration counter must reach DATA_WIDTH-1 without wrapping.
    function automatic int mul_cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/exu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, DATA_WIDTH cycles.
// done is high during the final iteration; product is valid while done is high.
module exu_mul_iter
    import exu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int CNT_W = mul_cnt_width(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);

    logic [DATA_WIDTH-1:0] mcand;
    logic [DATA_WIDTH-1:0] mplr;
    logic [DATA_WIDTH-1:0] acc;
    logic [CNT_W-1:0]      cnt;

    assign done    = busy && (cnt == LAST_CNT);
    // Folds in the last partial product so the result can be registered downstream this cycle.
    assign product = acc + (mplr[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            mcand <= op_a;
            mplr  <= op_b;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            if (mplr[0]) begin
                acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exu_mc.sv
// Multi-cycle RV32I execute unit: single-cycle ALU/branch/JAL/LUI plus optional iterative MUL.
// Define EXU_MC_MUL_EN to build the MUL path; otherwise MUL decodes as a bubble and hold_o is 0.
module exu_mc
    import exu_mc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_i,
    input  logic [31:0]           instr_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    input  logic [DATA_WIDTH-1:0] op1_i,
    input  logic [DATA_WIDTH-1:0] op2_i,
    input  logic [4:0]            rd_addr_i,
    input  logic                  wen_i,
    output logic [4:0]            rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  wen_o,
    output logic [DATA_WIDTH-1:0] jump_addr_o,
    output logic                  jump_en_o,
    output logic                  hold_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    logic [DATA_WIDTH-1:0] pc_ext, b_imm, j_imm, u_imm;
    logic [4:0]            nxt_rd;
    logic [DATA_WIDTH-1:0] nxt_data, nxt_jaddr;
    logic                  nxt_wen, nxt_jen;

    // Single-cycle result; anything not decoded here leaves the all-zero bubble.
    always_comb begin
        pc_ext                   = '0;
        pc_ext[ADDR_WIDTH-1:0]   = instr_addr_i;
        b_imm                    = {DATA_WIDTH{instr_i[31]}};
        b_imm[12:0]              = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        j_imm                    = {DATA_WIDTH{instr_i[31]}};
        j_imm[20:0]              = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
        u_imm                    = {DATA_WIDTH{instr_i[31]}};
        u_imm[31:0]              = {instr_i[31:12], 12'b0};
        nxt_rd    = '0;
        nxt_data  = '0;
        nxt_wen   = 1'b0;
        nxt_jaddr = '0;
        nxt_jen   = 1'b0;
        if (valid_i) begin
            case (opcode)
                OPC_I: begin
                    if (funct3 == F3_ADD_SUB) begin
                        nxt_rd   = rd_addr_i;
                        nxt_data = op1_i + op2_i;
                        nxt_wen  = wen_i;
                    end
                end
                OPC_R: begin
                    if (funct3 == F3_ADD_SUB && funct7 == F7_ADD) begin
                        nxt_rd   = rd_addr_i;
                        nxt_data = op1_i + op2_i;
                        nxt_wen  = wen_i;
                    end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
                        nxt_rd   = rd_addr_i;
                        nxt_data = op1_i - op2_i;
                        nxt_wen  = wen_i;
                    end
                end
                OPC_B: begin
                    if (funct3 == F3_BEQ) begin
                        nxt_jaddr = pc_ext + b_imm;
                        nxt_jen   = (op1_i == op2_i);
                    end else if (funct3 == F3_BNE) begin
                        nxt_jaddr = pc_ext + b_imm;
                        nxt_jen   = (op1_i != op2_i);
                    end
                end
                OPC_JAL: begin
                    nxt_rd    = instr_i[11:7];
                    nxt_data  = pc_ext + DATA_WIDTH'(4);
                    nxt_wen   = 1'b1;
                    nxt_jaddr = pc_ext + j_imm;
                    nxt_jen   = 1'b1;
                end
                OPC_LUI: begin
                    nxt_rd   = rd_addr_i;
                    nxt_data = u_imm;
                    nxt_wen  = 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef EXU_MC_MUL_EN
    exu_state_t            state;
    logic [4:0]            mul_rd;
    logic                  mul_wen;
    logic                  mul_busy, mul_done;
    logic [DATA_WIDTH-1:0] mul_product;
    logic                  is_mul, issue_mul;

    assign is_mul    = valid_i && opcode == OPC_R && funct3 == F3_MUL && funct7 == F7_MULDIV;
    assign issue_mul = is_mul && (state != ST_MUL);
    // Multiplier busy covers exactly the MUL state; the issue cycle adds the combinational term.
    assign hold_o    = mul_busy || issue_mul;

    exu_mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (issue_mul),
        .op_a    (op1_i),
        .op_b    (op2_i),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );
`else
    assign hold_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            wen_o       <= 1'b0;
            jump_addr_o <= '0;
            jump_en_o   <= 1'b0;
`ifdef EXU_MC_MUL_EN
            state       <= ST_IDLE;
            mul_rd      <= '0;
            mul_wen     <= 1'b0;
`endif
        end
`ifdef EXU_MC_MUL_EN
        else if (state == ST_MUL) begin
            rd_addr_o   <= '0;
            rd_data_o   <= '0;
            wen_o       <= 1'b0;
            jump_addr_o <= '0;
            jump_en_o   <= 1'b0;
            if (mul_done) begin
                rd_addr_o <= mul_rd;
                rd_data_o <= mul_product;
                wen_o     <= mul_wen;
                state     <= ST_DONE;
            end
        end
`endif
        else begin
            // IDLE and DONE both accept a new instruction.
            rd_addr_o   <= nxt_rd;
            rd_data_o   <= nxt_data;
            wen_o       <= nxt_wen;
            jump_addr_o <= nxt_jaddr;
            jump_en_o   <= nxt_jen;
`ifdef EXU_MC_MUL_EN
            if (issue_mul) begin
                state   <= ST_MUL;
                mul_rd  <= rd_addr_i;
                mul_wen <= wen_i;
            end else begin
                state   <= ST_IDLE;
            end
`endif
        end
    end

endmodule

// File: tb/tb_exu_mc.sv
// Bench for exu_mc: vector table, random ALU traffic, and MUL/reset sequences.
// Expectations adapt to whether EXU_MC_MUL_EN is defined.
module tb_exu_mc;

    localparam int DW = 32;
    localparam int AW = 12;
`ifdef EXU_MC_MUL_EN
    localparam logic MUL_EN = 1'b1;
`else
    localparam logic MUL_EN = 1'b0;
`endif

    typedef struct packed {
        logic          rstn;
        logic          valid;
        logic [31:0]   instr;
        logic [AW-1:0] pc;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [4:0]    rd;
        logic          wen;
    } in_t;

    typedef struct packed {
        logic [4:0]    rd;
        logic [DW-1:0] data;
        logic          wen;
        logic [DW-1:0] jaddr;
        logic          jen;
    } out_t;

    typedef struct {
        in_t   stim;
        out_t  expd;
        string name;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          valid_i = 1'b0;
    logic [31:0]   instr_i = '0;
    logic [AW-1:0] instr_addr_i = '0;
    logic [DW-1:0] op1_i = '0, op2_i = '0;
    logic [4:0]    rd_addr_i = '0;
    logic          wen_i = 1'b0;
    logic [4:0]    rd_addr_o;
    logic [DW-1:0] rd_data_o;
    logic          wen_o;
    logic [DW-1:0] jump_addr_o;
    logic          jump_en_o;
    logic          hold_o;

    out_t  exp_q[$];
    string name_q[$];
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;
    localparam out_t ZERO = '0;

    exu_mc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .instr_i(instr_i),
        .instr_addr_i(instr_addr_i), .op1_i(op1_i), .op2_i(op2_i),
        .rd_addr_i(rd_addr_i), .wen_i(wen_i), .rd_addr_o(rd_addr_o),
        .rd_data_o(rd_data_o), .wen_o(wen_o), .jump_addr_o(jump_addr_o),
        .jump_en_o(jump_en_o), .hold_o(hold_o)
    );

    always #5 clk = ~clk;

    // Instruction encoders
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, 5'd1, f3, rd, 7'b0010011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'b0110111};
    endfunction

    function automatic in_t mk_in(input logic v, input logic [31:0] ins, input logic [AW-1:0] pc,
                                  input logic [DW-1:0] a, input logic [DW-1:0] b,
                                  input logic [4:0] rd, input logic wen);
        in_t s;
        s.rstn = 1'b1; s.valid = v; s.instr = ins; s.pc = pc;
        s.op1 = a; s.op2 = b; s.rd = rd; s.wen = wen;
        return s;
    endfunction

    function automatic out_t mk_out(input logic [4:0] rd, input logic [DW-1:0] data, input logic wen,
                                    input logic [DW-1:0] jaddr, input logic jen);
        out_t o;
        o.rd = rd; o.data = data; o.wen = wen; o.jaddr = jaddr; o.jen = jen;
        return o;
    endfunction

    task automatic add_vec(input in_t s, input out_t e, input string n);
        vec_t v;
        v.stim = s; v.expd = e; v.name = n;
        vecs.push_back(v);
    endtask

    task automatic check_out();
        out_t  e, act;
        string n;
        e   = exp_q.pop_front();
        n   = name_q.pop_front();
        act = {rd_addr_o, rd_data_o, wen_o, jump_addr_o, jump_en_o};
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got rd=%0d data=%h wen=%b jaddr=%h jen=%b, expected rd=%0d data=%h wen=%b jaddr=%h jen=%b",
                     n, act.rd, act.data, act.wen, act.jaddr, act.jen, e.rd, e.data, e.wen, e.jaddr, e.jen);
        end
    endtask

    // Drive one cycle, check hold_o in that cycle, then check the registered outputs of the next.
    task automatic drive_cycle(input in_t s, input out_t e, input logic exp_hold, input string n);
        @(negedge clk);
        rst_n = s.rstn; valid_i = s.valid; instr_i = s.instr; instr_addr_i = s.pc;
        op1_i = s.op1; op2_i = s.op2; rd_addr_i = s.rd; wen_i = s.wen;
        exp_q.push_back(e);
        name_q.push_back(n);
        #1;
        checks++;
        if (hold_o !== exp_hold) begin
            errors++;
            $display("FAIL hold %s: got %b expected %b", n, hold_o, exp_hold);
        end
        if (!s.rstn) begin
            checks++;
            if ({rd_addr_o, rd_data_o, wen_o, jump_addr_o, jump_en_o} !== ZERO) begin
                errors++;
                $display("FAIL async_reset %s: outputs not cleared, data=%h wen=%b jen=%b",
                         n, rd_data_o, wen_o, jump_en_o);
            end
        end
        @(posedge clk);
        #2;
        check_out();
    endtask

    task automatic mul_seq(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [4:0] rd, input logic wen, input string n);
        logic [63:0] full;
        full = {32'b0, a} * {32'b0, b};
`ifdef EXU_MC_MUL_EN
        drive_cycle(mk_in(1'b1, enc_r(7'h01, 3'b000, rd), '0, a, b, rd, wen), ZERO, 1'b1, {n, " issue"});
        for (int i = 1; i <= DW; i++) begin
            drive_cycle(mk_in(1'b1, enc_r(7'h00, 3'b000, 5'd20), AW'($urandom), $urandom, $urandom, 5'd20, 1'b1),
                        (i == DW) ? mk_out(rd, full[DW-1:0], wen, '0, 1'b0) : ZERO, 1'b1, n);
        end
`else
        drive_cycle(mk_in(1'b1, enc_r(7'h01, 3'b000, rd), '0, a, b, rd, wen), ZERO, 1'b0,
                    $sformatf("%s bubble %h", n, full[DW-1:0]));
`endif
    endtask

    initial begin
        logic [DW-1:0] a, b;
        logic          sub, w;
        logic [4:0]    r;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({rd_addr_o, rd_data_o, wen_o, jump_addr_o, jump_en_o, hold_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: got data=%h wen=%b jaddr=%h jen=%b hold=%b expected all 0",
                     rd_data_o, wen_o, jump_addr_o, jump_en_o, hold_o);
        end

        add_vec(mk_in(1, enc_i(12'd7, 3'b000, 5'd3), '0, 5, 7, 5'd3, 1), mk_out(5'd3, 32'd12, 1, '0, 0), "addi");
        add_vec(mk_in(1, enc_r(7'h20, 3'b000, 5'd4), '0, 3, 5, 5'd4, 1), mk_out(5'd4, 32'hFFFF_FFFE, 1, '0, 0), "sub");
        add_vec(mk_in(1, 32'h0000_007F, '0, 1, 2, 5'd5, 1), ZERO, "invalid_opcode");
        add_vec(mk_in(1, enc_b(13'h1FF8, 3'b001), 12'h100, 1, 2, 5'd0, 0), mk_out('0, '0, 0, 32'hF8, 1), "bne_taken");
        add_vec(mk_in(1, enc_b(13'h1FF8, 3'b001), 12'h100, 9, 9, 5'd0, 0), mk_out('0, '0, 0, 32'hF8, 0), "bne_not_taken");
        add_vec(mk_in(1, enc_b(13'h1FF8, 3'b000), 12'h100, 9, 9, 5'd0, 0), mk_out('0, '0, 0, 32'hF8, 1), "beq_taken");
        add_vec(mk_in(1, enc_j(21'h20, 5'd1), 12'h040, 0, 0, 5'd0, 0), mk_out(5'd1, 32'h44, 1, 32'h60, 1), "jal");
        add_vec(mk_in(1, enc_u(20'h12345, 5'd7), '0, 0, 0, 5'd7, 1), mk_out(5'd7, 32'h1234_5000, 1, '0, 0), "lui");
        add_vec(mk_in(1, enc_u(20'hFFFFF, 5'd8), '0, 0, 0, 5'd8, 0), mk_out(5'd8, 32'hFFFF_F000, 1, '0, 0), "lui_neg");
        add_vec(mk_in(0, enc_r(7'h00, 3'b000, 5'd6), '0, 4, 4, 5'd6, 1), ZERO, "not_valid");
        add_vec(mk_in(1, enc_r(7'h00, 3'b000, 5'd9), '0, 10, 20, 5'd9, 0), mk_out(5'd9, 32'd30, 0, '0, 0), "add_nowen");
        add_vec(mk_in(1, enc_r(7'h00, 3'b000, 5'd10), '0, 32'hFFFF_FFFF, 1, 5'd10, 1), mk_out(5'd10, '0, 1, '0, 0), "add_wrap");
        add_vec(mk_in(1, enc_r(7'h10, 3'b000, 5'd11), '0, 1, 1, 5'd11, 1), ZERO, "bad_funct7");
        add_vec(mk_in(1, enc_b(13'h0010, 3'b000), 12'hFFC, 1, 2, 5'd0, 0), mk_out('0, '0, 0, 32'h100C, 0), "beq_pc_top");
        add_vec(mk_in(1, enc_j(21'h1FFFE0, 5'd2), 12'h010, 0, 0, 5'd0, 0), mk_out(5'd2, 32'h14, 1, 32'hFFFF_FFF0, 1), "jal_back");
        add_vec(mk_in(1, enc_b(13'h0010, 3'b010), 12'h100, 1, 2, 5'd0, 0), ZERO, "bad_branch_f3");
        add_vec(mk_in(1, enc_i(12'd1, 3'b010, 5'd12), '0, 1, 2, 5'd12, 1), ZERO, "slti_unsupported");

        for (int i = 0; i < vecs.size(); i++) begin
            drive_cycle(vecs[i].stim, vecs[i].expd, 1'b0, vecs[i].name);
        end

        // Back-to-back random ADD/SUB against a plain arithmetic model
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom;
            sub = 1'($urandom_range(0, 1));
            w   = 1'($urandom_range(0, 1));
            r   = 5'($urandom_range(1, 31));
            drive_cycle(mk_in(1, enc_r(sub ? 7'h20 : 7'h00, 3'b000, r), '0, a, b, r, w),
                        mk_out(r, sub ? a - b : a + b, w, '0, 0), 1'b0, $sformatf("rand_alu%0d", i));
        end

        // MUL then an ADD in the DONE cycle
        mul_seq(32'd6, 32'd7, 5'd13, 1'b1, "mul_6x7");
        drive_cycle(mk_in(1, enc_r(7'h00, 3'b000, 5'd14), '0, 100, 23, 5'd14, 1),
                    mk_out(5'd14, 32'd123, 1, '0, 0), 1'b0, "add_after_mul");
        // MUL issued straight from DONE, and a write-disabled MUL
        mul_seq(32'hFFFF_FFFF, 32'd2, 5'd15, 1'b1, "mul_ffffffff_x2");
        mul_seq(32'h1234_5678, 32'h9ABC_DEF0, 5'd16, 1'b0, "mul_nowen");
        drive_cycle(mk_in(0, '0, '0, 0, 0, 5'd0, 0), ZERO, 1'b0, "idle_after_mul");

        // Reset in cycle 10 of a MUL: no write-back may follow
        drive_cycle(mk_in(1, enc_r(7'h01, 3'b000, 5'd17), '0, 32'd100, 32'd3, 5'd17, 1), ZERO, MUL_EN, "mulrst issue");
        for (int i = 1; i < 10; i++) begin
            drive_cycle(mk_in(0, '0, '0, 0, 0, 5'd0, 0), ZERO, MUL_EN, "mulrst busy");
        end
        for (int i = 0; i < 2; i++) begin
            in_t s;
            s = mk_in(0, '0, '0, 0, 0, 5'd0, 0);
            s.rstn = 1'b0;
            drive_cycle(s, ZERO, 1'b0, "mulrst in_reset");
        end
        for (int i = 0; i < 40; i++) begin
            drive_cycle(mk_in(0, '0, '0, 0, 0, 5'd0, 0), ZERO, 1'b0, "mulrst after_release");
        end
        drive_cycle(mk_in(1, enc_i(12'd0, 3'b000, 5'd18), '0, 40, 2, 5'd18, 1),
                    mk_out(5'd18, 32'd42, 1, '0, 0), 1'b0, "addi_after_reset");

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/exu_mc.md
# exu_mc

Multi-cycle, parametrised execute unit for the RV32I core; the successor to the single-cycle combinational execute stage. Sits between the decode stage and the register-file write port / control unit. Executes ADDI, ADD, SUB, BEQ, BNE, JAL and LUI in one registered cycle, plus an iterative shift-add MUL that stalls upstream through `hold_o`. All outputs are registered.

## Interface
- `DATA_WIDTH`, default 32: operand/result width; must be ≥ 32.
- `ADDR_WIDTH`, default 12: instruction address width; zero-extended to `DATA_WIDTH` for arithmetic.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: reset; asynchronous, active-low.
- `valid_i` in 1: decode presents a valid instruction this cycle.
- `instr_i` in 32: raw instruction word.
- `instr_addr_i` in ADDR_WIDTH: PC of `instr_i`.
- `op1_i`, `op2_i` in DATA_WIDTH: rs1 value; rs2 value or immediate.
- `rd_addr_i` in 5: destination register.
- `wen_i` in 1: decode write-enable for R/I types.
- `rd_addr_o` out 5: write-back register.
- `rd_data_o` out DATA_WIDTH: write-back data.
- `wen_o` out 1: write-back strobe, one cycle per result.
- `jump_addr_o` out DATA_WIDTH: jump target.
- `jump_en_o` out 1: one-cycle jump pulse to control.
- `hold_o` out 1: stall request to control; combinational from state and inputs.

## Operation
- States: IDLE, MUL, DONE.
- **IDLE, `valid_i`=1, single-cycle op:**
  - Registers the result; outputs are valid in the next cycle for exactly one cycle.
  - ADDI/ADD: `op1+op2`. SUB: `op1-op2`. Both modulo 2^DATA_WIDTH. Write-back uses `rd_addr_i` and `wen_i`.
  - BEQ/BNE: `jump_addr_o` = PC + sign-extended B-immediate; `jump_en_o` = (op1==op2) for BEQ, (op1!=op2) for BNE; `wen_o`=0.
  - JAL: rd = `instr_i[11:7]`, data = PC+4, `wen_o`=1, target = PC + sign-extended J-immediate, `jump_en_o`=1.
  - LUI: data = `{instr_i[31:12],12'b0}`, sign-extended to DATA_WIDTH; `wen_o`=1.
  - Unsupported opcode/funct or `valid_i`=0: all outputs 0 next cycle (bubble).
- **IDLE, `valid_i`=1, MUL** (opcode R, funct3 000, funct7 0000001):
  - `hold_o`=1 combinationally in the issue cycle.
  - Captures op1, op2, rd, `wen_i`; clears the accumulator and counter; enters MUL.
- **MUL:**
  - Each cycle: if multiplier bit 0 = 1, add the multiplicand to the accumulator; multiplicand <<1, multiplier >>1, counter +1.
  - After DATA_WIDTH iterations, go to DONE.
  - `hold_o`=1 throughout. `valid_i` and all instruction inputs are ignored.
- **DONE:**
  - Outputs hold the low DATA_WIDTH bits of the product with `wen_o`=captured `wen_i`, for one cycle.
  - `hold_o`=0; returns to IDLE.
  - An instruction presented in this cycle is accepted as if in IDLE.
- Reset (including mid-MUL): returns to IDLE, discards the multiply, no write-back.

## Timing
- Reset value of every output is 0; state = IDLE; counter and accumulator = 0.
- Single-cycle ops: 1-cycle latency, full throughput (back-to-back every cycle).
- MUL issued at cycle 0:
  - `hold_o` high in cycles 0..DATA_WIDTH (DATA_WIDTH+1 cycles).
  - Result and `wen_o` appear in cycle DATA_WIDTH+1.
  - Next instruction is accepted in cycle DATA_WIDTH+1.
- `jump_en_o` and `wen_o` are single-cycle pulses; never asserted during MUL state.
- Counter width: `$clog2(DATA_WIDTH)+1`.

## Configuration
- `EXU_MC_MUL_EN` defined: MUL is supported as above.
- `EXU_MC_MUL_EN` undefined:
  - MUL decodes as unsupported (bubble, no hold).
  - The MUL/DONE states, multiplier sub-module and counter are not compiled.
  - `hold_o` is tied 0.

## Structure
- Shared package/defines: opcode constants (I, R, B, JAL, LUI); funct3 codes (ADD_SUB, BEQ, BNE, MUL); funct7 codes (ADD, SUB, MULDIV); state encoding.
- Sub-module `exu_mul_iter`: iterative shift-add multiplier.
  - Interface: start, operands, busy, done, product.
  - Instantiated only under `EXU_MC_MUL_EN`.

## Test plan
- ADDI op1=5, op2=7, rd=3, wen=1 → next cycle `rd_data_o`=12, `rd_addr_o`=3, `wen_o`=1 for one cycle.
- SUB op1=3, op2=5 → `rd_data_o`=0xFFFF_FFFE. Then invalid opcode 0x7F → all outputs 0.
- BNE at PC 0x100, imm −8:
  - op1≠op2 → `jump_addr_o`=0xF8, `jump_en_o`=1.
  - op1==op2 → `jump_en_o`=0.
  - BEQ with equal operands → `jump_en_o`=1.
- JAL at PC 0x40, imm +0x20, rd=1 → `rd_data_o`=0x44, `jump_addr_o`=0x60, both strobes high for one cycle.
- MUL 6×7 (DATA_WIDTH=32):
  - `hold_o` high 33 cycles; result 42 with `wen_o` at cycle 33.
  - ADD presented at cycle 33 is accepted, result at cycle 34.
  - 0xFFFF_FFFF×2 → 0xFFFF_FFFE.
- `rst_n` low at cycle 10 of a MUL → outputs 0, `hold_o`=0, no `wen_o` pulse after release. With `EXU_MC_MUL_EN` undefined, MUL → bubble, `hold_o`=0.
